// File: rtl/mem_stage_vl.sv
// MEM stage for a variable-latency data memory: holds the instruction until its in-order data_ok, zero added latency.
// Backpressure: mem_allowin drops while waiting on memory or WB; early responses are buffered; flushed requests are counted and their responses dropped.
module mem_stage_vl #(
    parameter int DATA_W  = 32,
    parameter int SIDE_W  = 80,
    parameter int MAX_OUT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_to_mem_valid,
    input  logic              ex_mem_req,
    input  logic [31:0]       ex_pc,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              ex_rf_we,
    input  logic [4:0]        ex_rf_waddr,
    input  logic              ex_ld,
    input  logic [1:0]        ex_ld_size,
    input  logic              ex_ld_unsigned,
    input  logic [SIDE_W-1:0] ex_side,
    output logic              mem_allowin,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,
    input  logic              wb_allowin,
    output logic              mem_to_wb_valid,
    output logic              mem_wb_rf_we,
    output logic [4:0]        mem_wb_rf_waddr,
    output logic [DATA_W-1:0] mem_wb_rf_wdata,
    output logic [31:0]       mem_wb_pc,
    output logic [SIDE_W-1:0] mem_wb_side,
    output logic              mem_fwd_stall,
    output logic              mem_discard_busy
);
    localparam int CW   = $clog2(MAX_OUT + 1);
    localparam int OFFW = $clog2(DATA_W / 8);

    logic              mem_valid_q, mem_valid_d;
    logic              req_q, rf_we_q, ld_q, ld_uns_q;
    logic [1:0]        ld_size_q;
    logic [4:0]        waddr_q;
    logic [31:0]       pc_q;
    logic [DATA_W-1:0] alu_q;
    logic [SIDE_W-1:0] side_q;
    logic              got_q, got_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic [CW-1:0]     disc_q, disc_d;
    logic [CW:0]       disc_sum;

    logic              own_ok, ready_go, load_en, capture;
    logic              inc_mem, inc_ex, dec_disc;
    logic [DATA_W-1:0] ld_data, shifted, ext;
    logic [OFFW-1:0]   off;

    // While older cancelled responses are pending, every data_ok belongs to them.
    assign own_ok      = data_ok & (disc_q == '0);
    assign ready_go    = ~req_q | got_q | own_ok;
    assign mem_allowin = ~mem_valid_q | (ready_go & wb_allowin);
    assign load_en     = ex_to_mem_valid & mem_allowin & ~flush;
    assign capture     = own_ok & mem_valid_q & req_q & ~got_q;

    always_comb begin
        mem_valid_d = mem_valid_q;
        if (flush)
            mem_valid_d = 1'b0;
        else if (mem_allowin)
            mem_valid_d = ex_to_mem_valid;
    end

    always_comb begin
        got_d  = got_q;
        rbuf_d = rbuf_q;
        if (flush || load_en) begin
            got_d = 1'b0;
        end else if (capture) begin
            got_d  = 1'b1;
            rbuf_d = rdata;
        end
    end

    assign inc_mem  = flush & mem_valid_q & req_q & ~got_q & ~own_ok;
    assign inc_ex   = flush & ex_to_mem_valid & ex_mem_req;
    assign dec_disc = data_ok & (disc_q != '0);
    assign disc_sum = {1'b0, disc_q} + (CW+1)'(inc_mem) + (CW+1)'(inc_ex) - (CW+1)'(dec_disc);
    assign disc_d   = disc_sum[CW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid_q <= 1'b0;
            req_q       <= 1'b0;
            rf_we_q     <= 1'b0;
            ld_q        <= 1'b0;
            ld_uns_q    <= 1'b0;
            ld_size_q   <= 2'b00;
            waddr_q     <= 5'd0;
            pc_q        <= 32'd0;
            alu_q       <= '0;
            side_q      <= '0;
            got_q       <= 1'b0;
            rbuf_q      <= '0;
            disc_q      <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            got_q       <= got_d;
            rbuf_q      <= rbuf_d;
            disc_q      <= disc_d;
            if (load_en) begin
                req_q     <= ex_mem_req;
                rf_we_q   <= ex_rf_we;
                ld_q      <= ex_ld;
                ld_uns_q  <= ex_ld_unsigned;
                ld_size_q <= ex_ld_size;
                waddr_q   <= ex_rf_waddr;
                pc_q      <= ex_pc;
                alu_q     <= ex_alu_result;
                side_q    <= ex_side;
            end
        end
    end

    // Lane select assumes naturally aligned accesses.
    assign ld_data = got_q ? rbuf_q : rdata;
    assign off     = alu_q[OFFW-1:0];
    assign shifted = ld_data >> {off, 3'b000};

    always_comb begin
        ext = shifted;
        case (ld_size_q)
            2'b00:   ext = ld_uns_q ? DATA_W'(shifted[7:0])  : DATA_W'($signed(shifted[7:0]));
            2'b01:   ext = ld_uns_q ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
            2'b10:   ext = ld_uns_q ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
            default: ext = shifted;
        endcase
    end

    assign mem_to_wb_valid  = mem_valid_q & ready_go;
    assign mem_wb_rf_we     = rf_we_q & mem_valid_q;
    assign mem_wb_rf_waddr  = waddr_q;
    assign mem_wb_rf_wdata  = ld_q ? ext : alu_q;
    assign mem_wb_pc        = pc_q;
    assign mem_wb_side      = side_q;
    assign mem_fwd_stall    = mem_valid_q & req_q & ld_q & ~got_q & ~own_ok;
    assign mem_discard_busy = (disc_q != '0);

    a_disc_range: assert property (@(posedge clk) disable iff (reset)
        disc_sum <= (CW+1)'(MAX_OUT));
    a_no_dword32: assert property (@(posedge clk) disable iff (reset)
        !(DATA_W == 32 && mem_valid_q && ld_q && ld_size_q == 2'b11));
endmodule

// File: tb/tb_mem_stage_vl.sv
// Directed bench for mem_stage_vl: scoreboard of WB results plus point checks on stall/allowin/discard state.
module tb_mem_stage_vl;
    logic        clk, reset, flush;
    logic        ex_to_mem_valid, ex_mem_req, ex_rf_we, ex_ld, ex_ld_unsigned;
    logic [31:0] ex_pc, ex_alu_result, rdata;
    logic [4:0]  ex_rf_waddr;
    logic [1:0]  ex_ld_size;
    logic [79:0] ex_side;
    logic        data_ok, wb_allowin;
    logic        mem_allowin, mem_to_wb_valid, mem_wb_rf_we, mem_fwd_stall, mem_discard_busy;
    logic [4:0]  mem_wb_rf_waddr;
    logic [31:0] mem_wb_rf_wdata, mem_wb_pc;
    logic [79:0] mem_wb_side;

    typedef struct {
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [79:0] side;
    } exp_t;
    exp_t q[$];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    mem_stage_vl dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_to_mem_valid(ex_to_mem_valid), .ex_mem_req(ex_mem_req), .ex_pc(ex_pc),
        .ex_alu_result(ex_alu_result), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
        .ex_ld(ex_ld), .ex_ld_size(ex_ld_size), .ex_ld_unsigned(ex_ld_unsigned),
        .ex_side(ex_side), .mem_allowin(mem_allowin), .data_ok(data_ok), .rdata(rdata),
        .wb_allowin(wb_allowin), .mem_to_wb_valid(mem_to_wb_valid), .mem_wb_rf_we(mem_wb_rf_we),
        .mem_wb_rf_waddr(mem_wb_rf_waddr), .mem_wb_rf_wdata(mem_wb_rf_wdata), .mem_wb_pc(mem_wb_pc),
        .mem_wb_side(mem_wb_side), .mem_fwd_stall(mem_fwd_stall), .mem_discard_busy(mem_discard_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        if (mem_to_wb_valid && wb_allowin) begin
            chk("sb_expected_present", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("wb_wdata", mem_wb_rf_wdata, e.wdata);
                chk("wb_pc", mem_wb_pc, e.pc);
                chk("wb_waddr", mem_wb_rf_waddr, e.waddr);
                chk("wb_side", mem_wb_side, e.side);
                chk("wb_rf_we", mem_wb_rf_we, 1'b1);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        sb_check();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic req, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [4:0] wa, input logic ld, input logic [1:0] sz, input logic uns);
        ex_to_mem_valid = v;
        ex_mem_req      = req;
        ex_pc           = pc;
        ex_alu_result   = alu;
        ex_rf_we        = 1'b1;
        ex_rf_waddr     = wa;
        ex_ld           = ld;
        ex_ld_size      = sz;
        ex_ld_unsigned  = uns;
        ex_side         = {16'hABCD, pc, ~pc};
    endtask

    task automatic push(input logic [31:0] wd, input logic [31:0] pc, input logic [4:0] wa);
        exp_t e;
        e.wdata = wd;
        e.pc    = pc;
        e.waddr = wa;
        e.side  = {16'hABCD, pc, ~pc};
        q.push_back(e);
    endtask

    task automatic idle();
        set_ex(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0);
    endtask

    logic [31:0] ext_addr [4] = '{32'h2003, 32'h2003, 32'h2002, 32'h2000};
    logic [1:0]  ext_size [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        ext_uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ext_exp  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8077, 32'h0000_F0A5};

    initial begin
        reset = 1'b1; flush = 1'b0; data_ok = 1'b0; rdata = 32'd0; wb_allowin = 1'b1;
        idle();
        #1;
        chk("rst_allowin", mem_allowin, 1'b1);
        chk("rst_to_wb_valid", mem_to_wb_valid, 1'b0);
        chk("rst_fwd_stall", mem_fwd_stall, 1'b0);
        chk("rst_discard_busy", mem_discard_busy, 1'b0);
        chk("rst_wdata", mem_wb_rf_wdata, 32'd0);
        adv(); adv();
        reset = 1'b0;

        // Word load, response three cycles after entry.
        set_ex(1'b1, 1'b1, 32'h100, 32'h1000, 5'd3, 1'b1, 2'b10, 1'b0);
        push(32'h8077_F0A5, 32'h100, 5'd3);
        cyc(); chk("lw_entry_allowin", mem_allowin, 1'b1); adv();
        idle();
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("lw_wait_stall", mem_fwd_stall, 1'b1);
            chk("lw_wait_no_valid", mem_to_wb_valid, 1'b0);
            adv();
        end
        data_ok = 1'b1; rdata = 32'h8077_F0A5;
        cyc();
        chk("lw_ok_valid", mem_to_wb_valid, 1'b1);
        chk("lw_ok_no_stall", mem_fwd_stall, 1'b0);
        adv();
        data_ok = 1'b0;

        // Byte/half extraction, pipelined one load per response.
        for (int i = 0; i < 4; i++) begin
            set_ex(1'b1, 1'b1, 32'h180 + 32'(i * 4), ext_addr[i], 5'(i + 10), 1'b1, ext_size[i], ext_uns[i]);
            push(ext_exp[i], 32'h180 + 32'(i * 4), 5'(i + 10));
            data_ok = (i > 0); rdata = 32'h8077_F0A5;
            cyc(); adv();
        end
        idle(); data_ok = 1'b1;
        cyc(); adv();
        data_ok = 1'b0;

        // Response arrives under WB backpressure and must be held.
        set_ex(1'b1, 1'b1, 32'h200, 32'h3000, 5'd7, 1'b1, 2'b10, 1'b0);
        push(32'h1234_5678, 32'h200, 5'd7);
        cyc(); adv();
        idle(); data_ok = 1'b1; rdata = 32'h1234_5678; wb_allowin = 1'b0;
        cyc();
        chk("bp_ok_valid", mem_to_wb_valid, 1'b1);
        chk("bp_ok_allowin", mem_allowin, 1'b0);
        adv();
        data_ok = 1'b0; rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bp_hold_valid", mem_to_wb_valid, 1'b1);
            chk("bp_hold_wdata", mem_wb_rf_wdata, 32'h1234_5678);
            chk("bp_hold_no_stall", mem_fwd_stall, 1'b0);
            adv();
        end
        wb_allowin = 1'b1;
        cyc(); adv();

        // Flush with a waiting load and an accepted EX request: two responses to drop.
        set_ex(1'b1, 1'b1, 32'h300, 32'h3100, 5'd8, 1'b1, 2'b10, 1'b0);
        cyc(); adv();
        set_ex(1'b1, 1'b1, 32'h3F0, 32'h3200, 5'd8, 1'b1, 2'b10, 1'b0);
        flush = 1'b1;
        cyc(); chk("fl_no_valid", mem_to_wb_valid, 1'b0); adv();
        flush = 1'b0;
        set_ex(1'b1, 1'b1, 32'h400, 32'h4000, 5'd9, 1'b1, 2'b10, 1'b0);
        push(32'hCAFE_F00D, 32'h400, 5'd9);
        data_ok = 1'b1; rdata = 32'hBADB_AD00;
        cyc();
        chk("fl_busy_after", mem_discard_busy, 1'b1);
        chk("fl_allowin_after", mem_allowin, 1'b1);
        chk("fl_drop1_no_valid", mem_to_wb_valid, 1'b0);
        adv();
        idle(); rdata = 32'hBADB_AD01;
        cyc();
        chk("fl_drop2_stall", mem_fwd_stall, 1'b1);
        chk("fl_drop2_no_valid", mem_to_wb_valid, 1'b0);
        chk("fl_drop2_busy", mem_discard_busy, 1'b1);
        adv();
        data_ok = 1'b0;
        cyc();
        chk("fl_drained_busy", mem_discard_busy, 1'b0);
        chk("fl_new_stall", mem_fwd_stall, 1'b1);
        adv();
        data_ok = 1'b1; rdata = 32'hCAFE_F00D;
        cyc(); chk("fl_third_ok_valid", mem_to_wb_valid, 1'b1); adv();
        data_ok = 1'b0;

        // Flush coincides with the instruction's own response.
        set_ex(1'b1, 1'b1, 32'h500, 32'h5000, 5'd4, 1'b1, 2'b10, 1'b0);
        cyc(); adv();
        idle(); data_ok = 1'b1; rdata = 32'h55; flush = 1'b1; wb_allowin = 1'b0;
        cyc(); chk("fo_no_stall", mem_fwd_stall, 1'b0); adv();
        flush = 1'b0; data_ok = 1'b0; wb_allowin = 1'b1;
        cyc();
        chk("fo_busy", mem_discard_busy, 1'b0);
        chk("fo_no_valid", mem_to_wb_valid, 1'b0);
        chk("fo_allowin", mem_allowin, 1'b1);
        adv();

        // Back-to-back ALU ops, then asynchronous reset mid-stream.
        for (int i = 0; i < 4; i++) begin
            set_ex(1'b1, 1'b0, 32'h600 + 32'(i * 4), 32'hA000_0000 + 32'(i * 32'h111), 5'(i + 1), 1'b0, 2'b10, 1'b0);
            push(32'hA000_0000 + 32'(i * 32'h111), 32'h600 + 32'(i * 4), 5'(i + 1));
            cyc();
            chk("alu_allowin", mem_allowin, 1'b1);
            chk("alu_no_stall", mem_fwd_stall, 1'b0);
            adv();
        end
        idle();
        #1;
        chk("alu_last_valid", mem_to_wb_valid, 1'b1);
        #1;
        reset = 1'b1;
        void'(q.pop_back());
        #1;
        chk("arst_to_wb_valid", mem_to_wb_valid, 1'b0);
        chk("arst_rf_we", mem_wb_rf_we, 1'b0);
        chk("arst_wdata", mem_wb_rf_wdata, 32'd0);
        chk("arst_pc", mem_wb_pc, 32'd0);
        chk("arst_waddr", mem_wb_rf_waddr, 5'd0);
        chk("arst_side", mem_wb_side, 80'd0);
        chk("arst_allowin", mem_allowin, 1'b1);
        chk("arst_busy", mem_discard_busy, 1'b0);
        cyc(); adv();
        reset = 1'b0;
        cyc();
        chk("sb_drained", q.size(), 0);
        adv();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
